uart_periph: RTL and testbench

Memory-mapped UART peripheral between the MIPS data-memory bus and the UART transmitter/receiver pair. It buffers received bytes and bytes to transmit in small FIFOs. It synchronises the UART status flags into the `sysclk` domain and sequences each transmit launch handshake, so the CPU never polls bit timing.

---
 rtl/uart_periph.sv | 205 ++++++++++++++++++++
 tb/tb_uart_periph.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_periph.sv
// Memory-mapped UART peripheral: TXD/RXD/CON registers, RX/TX FIFOs, status sync, TX launch FSM.
// Optional interrupt output enabled by defining UART_PERIPH_IRQ_EN.

module uart_periph_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  // A full FIFO still takes a push when the same cycle pops it
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

module uart_periph #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0018,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_status
`ifdef UART_PERIPH_IRQ_EN
  , output logic      irq
`endif
);
  localparam logic [31:0] A_TXD = BASE_ADDR;
  localparam logic [31:0] A_RXD = BASE_ADDR + 32'd4;
  localparam logic [31:0] A_CON = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_DRAIN} tx_state_t;

  tx_state_t r_state, w_next;

  logic                   w_wr_txd, w_rd_rxd, w_wr_con;
  logic [SYNC_STAGES-1:0] r_rx_sync, r_tx_sync;
  logic                   r_rx_prev, w_rx_rise, w_tx_idle;
  logic [7:0]             w_rx_head, w_tx_head, r_tx_data;
  logic                   w_rx_full, w_rx_empty, w_rx_drop;
  logic                   w_tx_full, w_tx_empty, w_tx_drop;
  logic                   w_tx_pop, w_busy;
  logic                   r_rx_ovf, r_tx_ovf, w_irq_en;
  logic                   w_unused;

  assign w_wr_txd = MemWrite & (Address == A_TXD);
  assign w_rd_rxd = MemRead  & (Address == A_RXD);
  assign w_wr_con = MemWrite & (Address == A_CON);
  assign w_unused = ^WriteData[31:8];

  // RX chain resets high so a receiver already holding "ready" is not seen as a new byte
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_sync <= '1;
      r_rx_prev <= 1'b1;
      r_tx_sync <= '0;
    end else begin
      r_rx_sync <= {r_rx_sync[SYNC_STAGES-2:0], rx_status};
      r_rx_prev <= r_rx_sync[SYNC_STAGES-1];
      r_tx_sync <= {r_tx_sync[SYNC_STAGES-2:0], tx_status};
    end
  end

  assign w_rx_rise = r_rx_sync[SYNC_STAGES-1] & ~r_rx_prev;
  assign w_tx_idle = r_tx_sync[SYNC_STAGES-1];

  uart_periph_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk    (sysclk),
    .rst    (reset),
    .i_push (w_rx_rise),
    .i_din  (rx_data),
    .i_pop  (w_rd_rxd),
    .o_head (w_rx_head),
    .o_full (w_rx_full),
    .o_empty(w_rx_empty),
    .o_drop (w_rx_drop)
  );

  uart_periph_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk    (sysclk),
    .rst    (reset),
    .i_push (w_wr_txd),
    .i_din  (WriteData[7:0]),
    .i_pop  (w_tx_pop),
    .o_head (w_tx_head),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty),
    .o_drop (w_tx_drop)
  );

  always_ff @(posedge sysclk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_tx_empty && w_tx_idle) w_next = S_LAUNCH;
      S_LAUNCH: if (!w_tx_idle)               w_next = S_DRAIN;
      S_DRAIN:  if (w_tx_idle)                w_next = S_IDLE;
      default:                                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_pop = (r_state == S_IDLE) & ~w_tx_empty & w_tx_idle;
    tx_start = (r_state == S_LAUNCH);
    w_busy   = (r_state != S_IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (reset)         r_tx_data <= 8'h00;
    else if (w_tx_pop) r_tx_data <= w_tx_head;
  end

  assign tx_data = r_tx_data;

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_rx_drop)                    r_rx_ovf <= 1'b1;
      else if (w_wr_con && WriteData[3]) r_rx_ovf <= 1'b0;
      if (w_tx_drop)                    r_tx_ovf <= 1'b1;
      else if (w_wr_con && WriteData[4]) r_tx_ovf <= 1'b0;
    end
  end

`ifdef UART_PERIPH_IRQ_EN
  logic r_irq_en, r_irq;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_con) r_irq_en <= WriteData[6];
      r_irq <= r_irq_en & (~w_rx_empty | (w_tx_empty & ~w_busy));
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  always_comb begin
    ReadData = '0;
    if (Address == A_RXD)
      ReadData = {24'b0, (w_rx_empty ? 8'h00 : w_rx_head)};
    else if (Address == A_CON)
      ReadData = {25'b0, w_irq_en, w_busy, r_tx_ovf, r_rx_ovf,
                  ~w_rx_empty, w_tx_empty, w_tx_full};
  end

  logic w_unused_full;
  assign w_unused_full = w_rx_full;
endmodule

// File: tb/tb_uart_periph.sv
// Directed bench for uart_periph: register access, RX/TX FIFOs, overflow, TX handshake, reset mid-launch.
module tb_uart_periph;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        sysclk = 1'b0;
  logic        reset, MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;
  logic [7:0]  rx_data, tx_data;
  logic        rx_status, tx_start, tx_status;
`ifdef UART_PERIPH_IRQ_EN
  logic        irq;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rd;

  uart_periph dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .rx_data  (rx_data),
    .rx_status(rx_status),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_status(tx_status)
`ifdef UART_PERIPH_IRQ_EN
    , .irq    (irq)
`endif
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge
  task automatic step(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    @(negedge sysclk);
    MemWrite = 1'b0; Address = '0; WriteData = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    Address = a; MemRead = 1'b1;
    #1 d = ReadData;
    @(negedge sysclk);
    MemRead = 1'b0; Address = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_status = 1'b1;
    step(4);
    rx_status = 1'b0;
    step(4);
  endtask

  task automatic wait_start(input logic lvl, input string tag);
    int n = 0;
    while (tx_start !== lvl && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    chk(tag, {31'b0, tx_start}, {31'b0, lvl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    rx_data = 8'h00; rx_status = 1'b0; tx_status = 1'b1;
    step(3);
    reset = 1'b0;

    // Reset state
    #1 chk("rst_readdata", ReadData, 32'h0);
    chk("rst_tx_start", {31'b0, tx_start}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    rd_chk("rst_con", A_CON, 32'h2);
    rd_chk("rst_rxd_empty", A_RXD, 32'h0);
    rd_chk("rst_con_again", A_CON, 32'h2);

    // Two-byte transmit with handshake
    bus_wr(A_TXD, 32'h41);
    chk("tx_start_n1", {31'b0, tx_start}, 32'h0);
    bus_wr(A_TXD, 32'h42);
    chk("tx_start_n2", {31'b0, tx_start}, 32'h1);
    chk("tx_data_41", {24'b0, tx_data}, 32'h41);
    step(3);
    chk("tx_start_hold", {31'b0, tx_start}, 32'h1);
    tx_status = 1'b0;
    wait_start(1'b0, "tx_start_drop");
    step(4);
    chk("tx_data_still_41", {24'b0, tx_data}, 32'h41);
    rd_chk("con_drain", A_CON, 32'h20);
    tx_status = 1'b1;
    wait_start(1'b1, "tx_start_42");
    chk("tx_data_42", {24'b0, tx_data}, 32'h42);
    tx_status = 1'b0;
    wait_start(1'b0, "tx_start_drop_42");
    tx_status = 1'b1;
    step(4);
    rd_chk("con_tx_done", A_CON, 32'h2);

    // RX overflow
    for (int i = 0; i < 5; i++) rx_push(8'h10 + 8'(i));
    rd_chk("con_rx_ovf", A_CON, 32'hE);
    rd_chk("rxd_10", A_RXD, 32'h10);
    rd_chk("rxd_11", A_RXD, 32'h11);
    rd_chk("rxd_12", A_RXD, 32'h12);
    rd_chk("rxd_13", A_RXD, 32'h13);
    rd_chk("rxd_empty", A_RXD, 32'h0);
    rd_chk("con_ovf_sticky", A_CON, 32'hA);
    bus_wr(A_CON, 32'h8);
    rd_chk("con_ovf_clr", A_CON, 32'h2);

    // Full RX FIFO: push and pop in the same edge
    for (int i = 0; i < 4; i++) rx_push(8'h20 + 8'(i));
    rx_data = 8'h24; rx_status = 1'b1;
    step(2);
    rd_chk("rxd_20_simul", A_RXD, 32'h20);
    rd_chk("con_no_ovf", A_CON, 32'h6);
    rx_status = 1'b0;
    step(4);
    rd_chk("rxd_21", A_RXD, 32'h21);
    rd_chk("rxd_22", A_RXD, 32'h22);
    rd_chk("rxd_23", A_RXD, 32'h23);
    rd_chk("rxd_24", A_RXD, 32'h24);
    rd_chk("rxd_empty2", A_RXD, 32'h0);

    // TX overflow with sender held busy
    tx_status = 1'b0;
    step(3);
    for (int i = 0; i < 5; i++) bus_wr(A_TXD, 32'h51 + 32'(i));
    rd_chk("con_tx_ovf", A_CON, 32'h11);
    bus_wr(A_CON, 32'h10);
    rd_chk("con_tx_ovf_clr", A_CON, 32'h01);
    for (int i = 0; i < 4; i++) begin
      tx_status = 1'b1;
      wait_start(1'b1, "ovf_launch");
      chk("ovf_tx_data", {24'b0, tx_data}, 32'h51 + 32'(i));
      tx_status = 1'b0;
      wait_start(1'b0, "ovf_drop");
    end
    tx_status = 1'b1;
    step(8);
    chk("ovf_no_fifth", {31'b0, tx_start}, 32'h0);
    rd_chk("con_ovf_end", A_CON, 32'h2);

    // Reset during LAUNCH
    bus_wr(A_TXD, 32'h61);
    bus_wr(A_TXD, 32'h62);
    chk("launch_before_rst", {31'b0, tx_start}, 32'h1);
    reset = 1'b1; tx_status = 1'b0;
    step(1);
    chk("rst_mid_tx_start", {31'b0, tx_start}, 32'h0);
    chk("rst_mid_tx_data", {24'b0, tx_data}, 32'h0);
    reset = 1'b0;
    rd_chk("rst_mid_con", A_CON, 32'h2);
    bus_wr(A_TXD, 32'h63);
    step(6);
    chk("no_launch_busy", {31'b0, tx_start}, 32'h0);
    rd_chk("con_pending", A_CON, 32'h0);
    tx_status = 1'b1;
    wait_start(1'b1, "launch_after_idle");
    chk("tx_data_63", {24'b0, tx_data}, 32'h63);
    tx_status = 1'b0;
    wait_start(1'b0, "drop_63");
    tx_status = 1'b1;
    step(4);

`ifdef UART_PERIPH_IRQ_EN
    begin
      int n = 0;
      tx_status = 1'b0;
      step(3);
      bus_wr(A_TXD, 32'h70);
      bus_wr(A_CON, 32'h40);
      step(2);
      chk("irq_low", {31'b0, irq}, 32'h0);
      rd_chk("con_irq_en", A_CON, 32'h40);
      rx_data = 8'h71; rx_status = 1'b1;
      Address = A_CON;
      #1;
      while (ReadData[2] !== 1'b1 && n < 20) begin
        @(negedge sysclk); #1;
        n++;
      end
      chk("irq_rx_avail", {31'b0, ReadData[2]}, 32'h1);
      chk("irq_not_yet", {31'b0, irq}, 32'h0);
      @(negedge sysclk); #1;
      chk("irq_high", {31'b0, irq}, 32'h1);
      Address = '0;
    end
`else
    bus_wr(A_CON, 32'h40);
    rd_chk("con_bit6_ignored", A_CON, 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
